// File: rtl/current_loop_sched_if.sv
// Bundles the current-loop scheduler's control, gain and status signals.
// The scheduler uses the slave modport; the driving environment uses master.
interface current_loop_sched_if;
   logic        iEnable;
   logic [15:0] iPeriod;
   logic        iModulate_done;
   logic [9:0]  iKp_d;
   logic [9:0]  iKi_d;
   logic [9:0]  iKp_q;
   logic [9:0]  iKi_q;
   logic        iParam_load;
   logic        iFault_clr;
   logic        oCL_en;
   logic [9:0]  oKp_d;
   logic [9:0]  oKi_d;
   logic [9:0]  oKp_q;
   logic [9:0]  oKi_q;
   logic        oBusy;
   logic        oFault;
   logic [15:0] oCycle_cnt;
   logic        oOverrun;
   logic [7:0]  oOverrun_cnt;

   modport master (
      output iEnable, iPeriod, iModulate_done,
      output iKp_d, iKi_d, iKp_q, iKi_q, iParam_load, iFault_clr,
      input  oCL_en, oKp_d, oKi_d, oKp_q, oKi_q,
      input  oBusy, oFault, oCycle_cnt, oOverrun, oOverrun_cnt
   );

   modport slave (
      input  iEnable, iPeriod, iModulate_done,
      input  iKp_d, iKi_d, iKp_q, iKi_q, iParam_load, iFault_clr,
      output oCL_en, oKp_d, oKi_d, oKp_q, oKi_q,
      output oBusy, oFault, oCycle_cnt, oOverrun, oOverrun_cnt
   );
endinterface

// File: rtl/current_loop_sched.sv
// Periodic kick scheduler for a current loop: period ticks, completion/timeout tracking,
// overrun detection and glitch-free PI gain handover. Optional CL_SCHED_OVERRUN_CNT_EN adds a saturating overrun counter.
module current_loop_sched #(
   parameter int TIMEOUT    = 4000,
   parameter int MIN_PERIOD = 16
) (
   input  logic                 iClk,
   input  logic                 iRst_n,
   current_loop_sched_if.slave  bus
);

   localparam int              TW           = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);
   localparam logic [15:0]     MIN_P        = 16'(MIN_PERIOD);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_TICK = 2'd1,
      RUN       = 2'd2,
      FAULT     = 2'd3
   } state_t;

   state_t        state_reg;
   logic [15:0]   period_cnt_reg;
   logic [15:0]   period_reg;
   logic [TW-1:0] timeout_cnt_reg;
   logic [15:0]   cycle_cnt_reg;
   logic          cl_en_reg;
   logic          busy_reg;
   logic          fault_reg;
   logic          overrun_reg;
   logic          pend_flag_reg;

   logic [15:0]   period_next;
   logic          counting;
   logic          tick;
   logic          kick;
   logic          overrun_evt;
   logic          gain_xfer;

   logic [3:0][9:0] gain_req;
   logic [3:0][9:0] gain_out;

   assign period_next = (bus.iPeriod < MIN_P) ? MIN_P : bus.iPeriod;
   assign counting    = (state_reg == WAIT_TICK) || (state_reg == RUN);
   assign tick        = counting && (period_cnt_reg == period_reg - 16'd1);
   assign kick        = (state_reg == WAIT_TICK) && bus.iEnable && tick;
   // A completion arriving on the tick cycle takes precedence over the overrun.
   assign overrun_evt = (state_reg == RUN) && tick && !bus.iModulate_done;
   assign gain_xfer   = pend_flag_reg &&
                        (kick || (state_reg == IDLE) || (state_reg == FAULT));

   assign gain_req[0] = bus.iKp_d;
   assign gain_req[1] = bus.iKi_d;
   assign gain_req[2] = bus.iKp_q;
   assign gain_req[3] = bus.iKi_q;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_gain
         logic [9:0] pend_reg;
         logic [9:0] gain_reg;

         always_ff @(posedge iClk or negedge iRst_n) begin
            if (!iRst_n) begin
               pend_reg <= '0;
               gain_reg <= '0;
            end else begin
               // Transfer uses the previously pending value; a same-edge load stays pending.
               if (gain_xfer) begin
                  gain_reg <= pend_reg;
               end
               if (bus.iParam_load) begin
                  pend_reg <= gain_req[gi];
               end
            end
         end

         assign gain_out[gi] = gain_reg;
      end
   endgenerate

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         pend_flag_reg <= 1'b0;
      end else if (bus.iParam_load) begin
         pend_flag_reg <= 1'b1;
      end else if (gain_xfer) begin
         pend_flag_reg <= 1'b0;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_reg       <= IDLE;
         period_cnt_reg  <= '0;
         period_reg      <= '0;
         timeout_cnt_reg <= '0;
         cycle_cnt_reg   <= '0;
         cl_en_reg       <= 1'b0;
         busy_reg        <= 1'b0;
         fault_reg       <= 1'b0;
         overrun_reg     <= 1'b0;
      end else begin
         cl_en_reg   <= 1'b0;
         overrun_reg <= overrun_evt;

         if (counting) begin
            if (tick) begin
               period_cnt_reg <= '0;
               period_reg     <= period_next;
            end else begin
               period_cnt_reg <= period_cnt_reg + 16'd1;
            end
         end

         case (state_reg)
            IDLE: begin
               if (bus.iEnable) begin
                  state_reg      <= WAIT_TICK;
                  period_cnt_reg <= '0;
                  period_reg     <= period_next;
               end
            end

            WAIT_TICK: begin
               if (!bus.iEnable) begin
                  state_reg <= IDLE;
               end else if (tick) begin
                  state_reg       <= RUN;
                  cl_en_reg       <= 1'b1;
                  busy_reg        <= 1'b1;
                  timeout_cnt_reg <= '0;
               end
            end

            RUN: begin
               if (bus.iModulate_done) begin
                  cycle_cnt_reg <= cycle_cnt_reg + 16'd1;
                  busy_reg      <= 1'b0;
                  state_reg     <= bus.iEnable ? WAIT_TICK : IDLE;
               end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                  busy_reg  <= 1'b0;
                  fault_reg <= 1'b1;
                  state_reg <= FAULT;
               end else begin
                  timeout_cnt_reg <= timeout_cnt_reg + TW'(1);
               end
            end

            FAULT: begin
               if (bus.iFault_clr) begin
                  fault_reg <= 1'b0;
                  state_reg <= IDLE;
               end
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

`ifdef CL_SCHED_OVERRUN_CNT_EN
   logic [7:0] overrun_cnt_reg;

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         overrun_cnt_reg <= '0;
      end else if ((state_reg == FAULT) && bus.iFault_clr) begin
         overrun_cnt_reg <= '0;
      end else if (overrun_evt && (overrun_cnt_reg != 8'hFF)) begin
         overrun_cnt_reg <= overrun_cnt_reg + 8'd1;
      end
   end

   assign bus.oOverrun_cnt = overrun_cnt_reg;
`else
   assign bus.oOverrun_cnt = 8'd0;
`endif

   assign bus.oCL_en     = cl_en_reg;
   assign bus.oBusy      = busy_reg;
   assign bus.oFault     = fault_reg;
   assign bus.oOverrun   = overrun_reg;
   assign bus.oCycle_cnt = cycle_cnt_reg;
   assign bus.oKp_d      = gain_out[0];
   assign bus.oKi_d      = gain_out[1];
   assign bus.oKp_q      = gain_out[2];
   assign bus.oKi_q      = gain_out[3];

endmodule

// File: tb/tb_current_loop_sched.sv
// Bench for current_loop_sched: table of period/latency scenarios plus hand-written
// overrun, coincidence, gain handover, timeout/fault and reset sequences.
module tb_current_loop_sched;

   logic clk;
   logic rst_n;

   current_loop_sched_if bus ();

   current_loop_sched #(
      .TIMEOUT    (4000),
      .MIN_PERIOD (16)
   ) dut (
      .iClk   (clk),
      .iRst_n (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef CL_SCHED_OVERRUN_CNT_EN
   localparam int EXP_OVR_CNT = 1;
`else
   localparam int EXP_OVR_CNT = 0;
`endif

   typedef struct {
      int period;
      int done_dly;
      int n_kicks;
      int exp_spacing;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          ncyc    = 0;
   int          kick_cnt = 0;
   int          last_kick = 0;
   int          ovr_seen = 0;
   logic [15:0] prev_cycle = '0;
   logic [15:0] model_cycle = '0;
   logic [15:0] sb_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("[TB] ok   %s = %0d", name, act);
      end
   endtask

   // Samples outputs on the falling edge; completed-cycle counts are checked against the scoreboard.
   task automatic step();
      @(negedge clk);
      ncyc++;
      if (bus.oCL_en) begin
         kick_cnt++;
         last_kick = ncyc;
      end
      if (bus.oOverrun) ovr_seen++;
      if (bus.oCycle_cnt !== prev_cycle) begin
         if (sb_q.size() == 0) chk("cycle_cnt_unexpected", 32'(bus.oCycle_cnt), 32'(prev_cycle));
         else                  chk("cycle_cnt_sb", 32'(bus.oCycle_cnt), 32'(sb_q.pop_front()));
         prev_cycle = bus.oCycle_cnt;
      end
   endtask

   task automatic clear_model();
      prev_cycle  = '0;
      model_cycle = '0;
      sb_q.delete();
   endtask

   task automatic do_reset();
      rst_n              = 1'b0;
      bus.iEnable        = 1'b0;
      bus.iModulate_done = 1'b0;
      bus.iParam_load    = 1'b0;
      bus.iFault_clr     = 1'b0;
      #1;
      clear_model();
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic pulse_done(input bit counted);
      if (counted) begin
         model_cycle++;
         sb_q.push_back(model_cycle);
      end
      bus.iModulate_done = 1'b1;
      step();
      bus.iModulate_done = 1'b0;
   endtask

   task automatic wait_kick(input int bound, output int at);
      int k0;
      k0 = kick_cnt;
      at = -1;
      for (int i = 0; i < bound; i++) begin
         step();
         if (kick_cnt != k0) begin
            at = last_kick;
            break;
         end
      end
      if (at < 0) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL wait_kick: no kick within %0d cycles", bound);
         at = ncyc;
      end
   endtask

   task automatic set_gains(input int kp_d, input int ki_d, input int kp_q, input int ki_q);
      bus.iKp_d = 10'(kp_d);
      bus.iKi_d = 10'(ki_d);
      bus.iKp_q = 10'(kp_q);
      bus.iKi_q = 10'(ki_q);
      bus.iParam_load = 1'b1;
      step();
      bus.iParam_load = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[4];
      int   at, prev_at, kc, ov0, cm, en_at;

      vecs[0] = '{period: 100, done_dly: 20, n_kicks: 10, exp_spacing: 100};
      vecs[1] = '{period: 5,   done_dly: 3,  n_kicks: 4,  exp_spacing: 16};
      vecs[2] = '{period: 16,  done_dly: 14, n_kicks: 3,  exp_spacing: 16};
      vecs[3] = '{period: 37,  done_dly: 10, n_kicks: 3,  exp_spacing: 37};

      bus.iPeriod = 16'd0;
      set_gains(0, 0, 0, 0);
      do_reset();

      chk("rst_cl_en",       32'(bus.oCL_en), 0);
      chk("rst_busy",        32'(bus.oBusy), 0);
      chk("rst_fault",       32'(bus.oFault), 0);
      chk("rst_overrun",     32'(bus.oOverrun), 0);
      chk("rst_cycle_cnt",   32'(bus.oCycle_cnt), 0);
      chk("rst_overrun_cnt", 32'(bus.oOverrun_cnt), 0);
      chk("rst_kp_d",        32'(bus.oKp_d), 0);
      chk("rst_ki_q",        32'(bus.oKi_q), 0);

      // Table: first-kick latency, kick spacing, cycle count and stop-after-done.
      for (int i = 0; i < 4; i++) begin
         do_reset();
         bus.iPeriod = 16'(vecs[i].period);
         bus.iEnable = 1'b1;
         en_at = ncyc;
         wait_kick(vecs[i].exp_spacing + 5, at);
         chk($sformatf("v%0d_first_kick_lat", i), 32'(at - en_at), 32'(vecs[i].exp_spacing + 1));
         for (int k = 0; k < vecs[i].n_kicks; k++) begin
            prev_at = at;
            repeat (vecs[i].done_dly) step();
            if (k == vecs[i].n_kicks - 1) bus.iEnable = 1'b0;
            pulse_done(1'b1);
            if (k < vecs[i].n_kicks - 1) begin
               wait_kick(vecs[i].exp_spacing + 5, at);
               chk($sformatf("v%0d_spacing_k%0d", i, k), 32'(at - prev_at), 32'(vecs[i].exp_spacing));
            end
         end
         chk($sformatf("v%0d_busy_after_last_done", i), 32'(bus.oBusy), 0);
         kc = kick_cnt;
         repeat (2 * vecs[i].exp_spacing + 4) step();
         chk($sformatf("v%0d_no_kick_after_disable", i), 32'(kick_cnt - kc), 0);
         chk($sformatf("v%0d_cycle_cnt", i), 32'(bus.oCycle_cnt), 32'(vecs[i].n_kicks));
         chk($sformatf("v%0d_sb_empty", i), 32'(sb_q.size()), 0);
      end

      // Gains loaded while idle reach the outputs on the following edge.
      do_reset();
      set_gains(7, 8, 9, 10);
      step();
      chk("idle_gain_kp_d", 32'(bus.oKp_d), 7);
      chk("idle_gain_ki_q", 32'(bus.oKi_q), 10);

      // Mid-RUN gain load plus a withheld completion causing one overrun.
      bus.iPeriod = 16'd100;
      bus.iEnable = 1'b1;
      wait_kick(110, at);
      kc  = kick_cnt;
      ov0 = ovr_seen;
      repeat (5) step();
      set_gains(300, 301, 302, 303);
      repeat (144) step();
      chk("run_gain_held_kp_d", 32'(bus.oKp_d), 7);
      chk("overrun_pulses",     32'(ovr_seen - ov0), 1);
      chk("overrun_no_kick",    32'(kick_cnt - kc), 0);
      chk("overrun_busy",       32'(bus.oBusy), 1);
      chk("overrun_cnt",        32'(bus.oOverrun_cnt), 32'(EXP_OVR_CNT));
      prev_at = at;
      pulse_done(1'b1);
      chk("wait_gain_held_kp_d", 32'(bus.oKp_d), 7);
      wait_kick(110, at);
      chk("overrun_next_spacing", 32'(at - prev_at), 200);
      chk("kick_gain_kp_d",       32'(bus.oKp_d), 300);
      chk("kick_gain_ki_q",       32'(bus.oKi_q), 303);

      // Completion on the very tick cycle: counted, no overrun, that tick gives no kick.
      prev_at = at;
      ov0 = ovr_seen;
      repeat (99) step();
      pulse_done(1'b1);
      wait_kick(210, at);
      chk("coincide_spacing",    32'(at - prev_at), 200);
      chk("coincide_no_overrun", 32'(ovr_seen - ov0), 0);

      // No completion at all: fault exactly TIMEOUT cycles after the kick.
      kc = kick_cnt;
      repeat (3999) step();
      chk("timeout_fault_before", 32'(bus.oFault), 0);
      chk("timeout_busy_before",  32'(bus.oBusy), 1);
      step();
      chk("timeout_fault_at",     32'(bus.oFault), 1);
      chk("timeout_busy_at",      32'(bus.oBusy), 0);
      chk("timeout_no_kick",      32'(kick_cnt - kc), 0);
      pulse_done(1'b0);
      repeat (250) step();
      chk("fault_no_kick",        32'(kick_cnt - kc), 0);
      chk("fault_cycle_cnt_held", 32'(bus.oCycle_cnt), 32'(model_cycle));
      chk("fault_still_set",      32'(bus.oFault), 1);
      cm = ncyc;
      bus.iFault_clr = 1'b1;
      step();
      bus.iFault_clr = 1'b0;
      chk("clr_fault",       32'(bus.oFault), 0);
      chk("clr_overrun_cnt", 32'(bus.oOverrun_cnt), 0);
      wait_kick(120, at);
      chk("resume_kick_lat", 32'(at - cm), 102);

      // Asynchronous reset in the middle of RUN, then a stray completion while idle.
      kc = kick_cnt;
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy",      32'(bus.oBusy), 0);
      chk("async_rst_cycle_cnt", 32'(bus.oCycle_cnt), 0);
      chk("async_rst_kp_d",      32'(bus.oKp_d), 0);
      clear_model();
      bus.iEnable = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      pulse_done(1'b0);
      repeat (20) step();
      chk("stray_done_cycle_cnt", 32'(bus.oCycle_cnt), 0);
      chk("stray_done_busy",      32'(bus.oBusy), 0);
      chk("stray_done_no_kick",   32'(kick_cnt - kc), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
